// File: rtl/blur_pkg.sv
// rtl/blur_pkg.sv - shared constants, types and divide-by-9 helper for the 3x3 box blur
package blur_pkg;

    localparam int IMG_W      = 256;
    localparam int IMG_H      = 256;
    localparam int LATENCY    = 3;
    localparam int PIX_W      = 12;
    localparam int CH_W       = 4;
    localparam int DIV9_MUL   = 57;
    localparam int DIV9_SHIFT = 9;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } blur_state_e;

    // 57/512 approximates 1/9 closely enough that the floor matches sum/9 for every sum up to 135
    function automatic logic [CH_W-1:0] div9_sat(input logic [7:0] sum);
        logic [13:0] prod;
        prod = 14'(sum) * 14'(DIV9_MUL);
        if (prod[13:DIV9_SHIFT] > 5'd15) begin
            return 4'hF;
        end
        return prod[DIV9_SHIFT+CH_W-1:DIV9_SHIFT];
    endfunction

endpackage

// File: rtl/box_blur_3x3_if.sv
// rtl/box_blur_3x3_if.sv - raster video in/out bundle between sync generator, blur stage and DAC
interface box_blur_3x3_if;

    logic        i_pix_en;
    logic        i_hsync;
    logic        i_vsync;
    logic        i_blank;
    logic [9:0]  i_x;
    logic [8:0]  i_y;
    logic [11:0] i_pix;
    logic        i_blur_en;
    logic [3:0]  o_red;
    logic [3:0]  o_green;
    logic [3:0]  o_blue;
    logic        o_hsync;
    logic        o_vsync;
    logic        o_blank;

    modport slave (
        input  i_pix_en, i_hsync, i_vsync, i_blank, i_x, i_y, i_pix, i_blur_en,
        output o_red, o_green, o_blue, o_hsync, o_vsync, o_blank
    );

    modport master (
        output i_pix_en, i_hsync, i_vsync, i_blank, i_x, i_y, i_pix, i_blur_en,
        input  o_red, o_green, o_blue, o_hsync, o_vsync, o_blank
    );

endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image row of pixels, read-first single-port RAM
module line_buffer
    import blur_pkg::*;
#(
    parameter int DEPTH = IMG_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  pix_t          wdata,
    output pix_t          rdata
);

    pix_t mem_q [DEPTH];

    // Asynchronous read returns the old word during the write cycle
    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/box_blur_3x3.sv
// rtl/box_blur_3x3.sv - 3x3 box-blur stage between the VGA sync generator and the DAC pins
module box_blur_3x3
    import blur_pkg::*;
#(
    parameter int W = IMG_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    box_blur_3x3_if.slave vif
);

    localparam int AW = $clog2(W);

    logic          active;
    logic          frame_start;
    logic [AW-1:0] lb_addr;
    pix_t          lb0_rd;
    pix_t          lb1_rd;

    blur_state_e state_q, state_d;
    pix_t        win_q [3][3];
    pix_t        win_d [3][3];

    logic s1_bypass_q, s1_bypass_d;
    logic s1_run_q,    s1_run_d;
    logic s1_blank_q,  s1_blank_d;
    logic s1_hs_q,     s1_hs_d;
    logic s1_vs_q,     s1_vs_d;

    logic [7:0] s2_sum_q [3];
    logic [7:0] s2_sum_d [3];
    pix_t       s2_centre_q, s2_centre_d;
    logic       s2_bypass_q, s2_bypass_d;
    logic       s2_run_q,    s2_run_d;
    logic       s2_blank_q,  s2_blank_d;
    logic       s2_hs_q,     s2_hs_d;
    logic       s2_vs_q,     s2_vs_d;

    pix_t rgb_q,   rgb_d;
    logic o_hs_q,  o_hs_d;
    logic o_vs_q,  o_vs_d;
    logic o_blk_q, o_blk_d;

    assign active      = vif.i_pix_en && !vif.i_blank;
    assign frame_start = active && (vif.i_x == '0) && (vif.i_y == '0);
    assign lb_addr     = vif.i_x[AW-1:0];

    line_buffer #(.DEPTH(W), .AW(AW)) u_lb0 (
        .clk   (i_clk),
        .en    (active && !i_rst),
        .addr  (lb_addr),
        .wdata (vif.i_pix),
        .rdata (lb0_rd)
    );

    line_buffer #(.DEPTH(W), .AW(AW)) u_lb1 (
        .clk   (i_clk),
        .en    (active && !i_rst),
        .addr  (lb_addr),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        s1_bypass_d = s1_bypass_q;
        s1_run_d    = s1_run_q;
        s1_blank_d  = s1_blank_q;
        s1_hs_d     = s1_hs_q;
        s1_vs_d     = s1_vs_q;
        s2_sum_d    = s2_sum_q;
        s2_centre_d = s2_centre_q;
        s2_bypass_d = s2_bypass_q;
        s2_run_d    = s2_run_q;
        s2_blank_d  = s2_blank_q;
        s2_hs_d     = s2_hs_q;
        s2_vs_d     = s2_vs_q;
        rgb_d       = rgb_q;
        o_hs_d      = o_hs_q;
        o_vs_d      = o_vs_q;
        o_blk_d     = o_blk_q;

        if (vif.i_pix_en) begin
            if (state_q == WAIT_FRAME && frame_start) begin
                state_d = RUN;
            end

            // Column 2 is the newest: rows top to bottom are two lines ago, one line ago, now
            if (active) begin
                for (int r = 0; r < 3; r++) begin
                    win_d[r][0] = win_q[r][1];
                    win_d[r][1] = win_q[r][2];
                end
                win_d[0][2] = lb1_rd;
                win_d[1][2] = lb0_rd;
                win_d[2][2] = vif.i_pix;
            end

            s1_bypass_d = (vif.i_x < 10'd2) || (vif.i_y < 9'd2) || !vif.i_blur_en;
            s1_run_d    = (state_d == RUN);
            s1_blank_d  = vif.i_blank;
            s1_hs_d     = vif.i_hsync;
            s1_vs_d     = vif.i_vsync;

            for (int c = 0; c < 3; c++) begin
                s2_sum_d[c] = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int k = 0; k < 3; k++) begin
                        s2_sum_d[c] = s2_sum_d[c] + {4'b0, win_q[r][k][c*CH_W +: CH_W]};
                    end
                end
            end
            s2_centre_d = win_q[1][1];
            s2_bypass_d = s1_bypass_q;
            s2_run_d    = s1_run_q;
            s2_blank_d  = s1_blank_q;
            s2_hs_d     = s1_hs_q;
            s2_vs_d     = s1_vs_q;

            for (int c = 0; c < 3; c++) begin
                rgb_d[c*CH_W +: CH_W] = s2_bypass_q ? s2_centre_q[c*CH_W +: CH_W]
                                                    : div9_sat(s2_sum_q[c]);
            end
            if (!s2_run_q || s2_blank_q) begin
                rgb_d = '0;
            end
            o_hs_d  = s2_hs_q;
            o_vs_d  = s2_vs_q;
            o_blk_d = s2_blank_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= WAIT_FRAME;
            for (int r = 0; r < 3; r++) begin
                for (int k = 0; k < 3; k++) begin
                    win_q[r][k] <= '0;
                end
            end
            s1_bypass_q <= 1'b0;
            s1_run_q    <= 1'b0;
            s1_blank_q  <= 1'b1;
            s1_hs_q     <= 1'b1;
            s1_vs_q     <= 1'b1;
            for (int c = 0; c < 3; c++) begin
                s2_sum_q[c] <= '0;
            end
            s2_centre_q <= '0;
            s2_bypass_q <= 1'b0;
            s2_run_q    <= 1'b0;
            s2_blank_q  <= 1'b1;
            s2_hs_q     <= 1'b1;
            s2_vs_q     <= 1'b1;
            rgb_q       <= '0;
            o_hs_q      <= 1'b1;
            o_vs_q      <= 1'b1;
            o_blk_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            s1_bypass_q <= s1_bypass_d;
            s1_run_q    <= s1_run_d;
            s1_blank_q  <= s1_blank_d;
            s1_hs_q     <= s1_hs_d;
            s1_vs_q     <= s1_vs_d;
            s2_sum_q    <= s2_sum_d;
            s2_centre_q <= s2_centre_d;
            s2_bypass_q <= s2_bypass_d;
            s2_run_q    <= s2_run_d;
            s2_blank_q  <= s2_blank_d;
            s2_hs_q     <= s2_hs_d;
            s2_vs_q     <= s2_vs_d;
            rgb_q       <= rgb_d;
            o_hs_q      <= o_hs_d;
            o_vs_q      <= o_vs_d;
            o_blk_q     <= o_blk_d;
        end
    end

    assign vif.o_red   = rgb_q[11:8];
    assign vif.o_green = rgb_q[7:4];
    assign vif.o_blue  = rgb_q[3:0];
    assign vif.o_hsync = o_hs_q;
    assign vif.o_vsync = o_vs_q;
    assign vif.o_blank = o_blk_q;

endmodule

// File: tb/tb_box_blur_3x3.sv
// tb/tb_box_blur_3x3.sv - randomized scoreboard bench for box_blur_3x3 on a reduced raster
module tb_box_blur_3x3;

    localparam int W  = 16;
    localparam int H  = 14;
    localparam int HT = W + 6;
    localparam int VT = H + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick_seen = 1'b0;

    always #5 clk = ~clk;

    box_blur_3x3_if vif();

    box_blur_3x3 #(.W(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .vif   (vif)
    );

    typedef struct {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        known;
    } exp_t;

    exp_t exp_q[$];
    int   hist[$];
    bit   running;
    bit   fresh;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic exp_t idle_exp();
        exp_t e;
        e.rgb = '0; e.hs = 1'b1; e.vs = 1'b1; e.blank = 1'b1; e.known = 1'b1;
        return e;
    endfunction

    always @(posedge clk) tick_seen <= vif.i_pix_en && !rst;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (tick_seen) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.known) check("rgb", {vif.o_red, vif.o_green, vif.o_blue}, int'(e.rgb));
                check("hs_vs_blank", {vif.o_hsync, vif.o_vsync, vif.o_blank}, {e.hs, e.vs, e.blank});
            end
        end
    end

    // Reference: hist holds every written pixel in raster order, so one row up is W entries back
    task automatic drive(input int col, input int row, input logic [11:0] pix, input logic blur, input int stall);
        exp_t e;
        int   n, ci, val, sum;
        logic blank;
        blank = (col >= W) || (row >= H);
        vif.i_x      = 10'(col);
        vif.i_y      = 9'(row);
        vif.i_blank  = blank;
        vif.i_hsync  = !(col == W + 2 || col == W + 3);
        vif.i_vsync  = !(row == H);
        vif.i_pix    = pix;
        vif.i_blur_en = blur;
        vif.i_pix_en = 1'b1;
        e.rgb = '0; e.hs = vif.i_hsync; e.vs = vif.i_vsync; e.blank = blank; e.known = 1'b1;
        if (!blank) begin
            n = hist.size();
            hist.push_back(int'(pix));
            if (col == 0 && row == 0) running = 1'b1;
            if (running) begin
                ci = n - 1 - W;
                if (col < 2 || row < 2 || !blur) begin
                    if (fresh) e.rgb = '0;
                    else if (ci < 0) e.known = 1'b0;
                    else e.rgb = 12'(hist[ci]);
                end else begin
                    val = 0;
                    for (int ch = 0; ch < 3; ch++) begin
                        sum = 0;
                        for (int r = 0; r < 3; r++)
                            for (int k = 0; k < 3; k++)
                                sum += (hist[n - k - r * W] >> (4 * ch)) & 15;
                        val |= (sum / 9) << (4 * ch);
                    end
                    e.rgb = 12'(val);
                end
            end
            fresh = 1'b0;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        vif.i_pix_en = 1'b0;
        repeat (stall) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vif.i_pix_en = 1'b1;
        @(posedge clk); #1;
        vif.i_pix_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rgb", {vif.o_red, vif.o_green, vif.o_blue}, 0);
        check("rst_hsync", vif.o_hsync, 1);
        check("rst_vsync", vif.o_vsync, 1);
        check("rst_blank", vif.o_blank, 1);
        exp_q.delete();
        exp_q.push_back(idle_exp());
        exp_q.push_back(idle_exp());
        running = 1'b0;
        fresh   = 1'b1;
    endtask

    // kind: 0 random, 1 flat A5C, 2 single white dot at (10,10), 3 horizontal gradient
    task automatic run_frame(input int kind, input int blur_mode, input bit slow, input int rst_row);
        logic [11:0] pix;
        logic [3:0]  g;
        logic        blur;
        int          stall;
        for (int row = 0; row < VT; row++) begin
            for (int col = 0; col < HT; col++) begin
                if (row == rst_row && col == W + 1) do_reset();
                g = 4'(col);
                case (kind)
                    0:       pix = 12'($urandom_range(0, 4095));
                    1:       pix = 12'hA5C;
                    2:       pix = (col == 10 && row == 10) ? 12'hFFF : 12'h000;
                    default: pix = {g, g, g};
                endcase
                blur  = (blur_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(blur_mode);
                stall = slow ? 3 + int'($urandom_range(0, 3)) : 0;
                drive(col, row, pix, blur, stall);
            end
        end
    endtask

    initial begin
        vif.i_pix_en = 1'b0; vif.i_hsync = 1'b1; vif.i_vsync = 1'b1; vif.i_blank = 1'b1;
        vif.i_x = '0; vif.i_y = '0; vif.i_pix = '0; vif.i_blur_en = 1'b1;
        do_reset();

        run_frame(0, 1, 1'b0, -1);
        run_frame(0, 2, 1'b0, -1);
        run_frame(1, 1, 1'b0, 3);
        run_frame(1, 1, 1'b0, -1);
        run_frame(2, 1, 1'b0, -1);
        run_frame(2, 0, 1'b0, -1);
        run_frame(3, 1, 1'b0, -1);
        run_frame(0, 2, 1'b1, -1);
        run_frame(0, 1, 1'b1, -1);
        run_frame(0, 1, 1'b0, -1);

        @(negedge clk); #1;
        check("pipeline_depth", exp_q.size(), 2);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
